// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: synchronise, glitch-filter, frame and fold E0/F0 prefixes into a toggle-strobe key word.
// Optional build macro PS2_RX_TIMEOUT_EN adds a mid-frame idle timeout.
`timescale 1ns/1ps
module ps2_key_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [10:0] ps2_key,
    output logic        rx_err
);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic       clk_s1, clk_s2, dat_s1, dat_s2;
    logic [7:0] flt_cnt;
    logic       fclk, fclk_q, fall;

    state_t     state;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic       par;
    logic       byte_rdy;
    logic [7:0] byte_q;
    logic       frame_err;
    logic       tmo;
    logic       ext_f, rel_f;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            dat_s1  <= 1'b1;
            dat_s2  <= 1'b1;
            flt_cnt <= '0;
            fclk    <= 1'b1;
            fclk_q  <= 1'b1;
            fall    <= 1'b0;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
            // fclk follows only after FILTER_LEN consecutive samples at the new level
            if (clk_s2 == fclk) begin
                flt_cnt <= '0;
            end else if (flt_cnt == 8'(FILTER_LEN - 1)) begin
                fclk    <= clk_s2;
                flt_cnt <= '0;
            end else begin
                flt_cnt <= flt_cnt + 8'd1;
            end
            fclk_q <= fclk;
            fall   <= fclk_q & ~fclk;
        end
    end

`ifdef PS2_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] idle_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idle_cnt <= '0;
        end else if (fall || state == S_IDLE || tmo) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    assign tmo = (state != S_IDLE) && !fall && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
    assign tmo = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            par       <= 1'b0;
            byte_rdy  <= 1'b0;
            byte_q    <= '0;
            frame_err <= 1'b0;
        end else begin
            byte_rdy  <= 1'b0;
            frame_err <= 1'b0;
            if (fall) begin
                case (state)
                    S_IDLE: begin
                        if (!dat_s2) begin
                            state   <= S_DATA;
                            bit_cnt <= '0;
                        end
                    end
                    S_DATA: begin
                        shreg   <= {dat_s2, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= S_PARITY;
                    end
                    S_PARITY: begin
                        par   <= dat_s2;
                        state <= S_STOP;
                    end
                    default: begin
                        if (dat_s2 && (^{shreg, par})) begin
                            byte_rdy <= 1'b1;
                            byte_q   <= shreg;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        state <= S_IDLE;
                    end
                endcase
            end else if (tmo) begin
                state <= S_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ps2_key <= '0;
            rx_err  <= 1'b0;
            ext_f   <= 1'b0;
            rel_f   <= 1'b0;
        end else begin
            rx_err <= frame_err | tmo;
            if (frame_err || tmo) begin
                ext_f <= 1'b0;
                rel_f <= 1'b0;
            end else if (byte_rdy) begin
                case (byte_q)
                    8'hE0: ext_f <= 1'b1;
                    8'hF0: rel_f <= 1'b1;
                    8'hE1: ;
                    8'h00, 8'hEE, 8'hFA, 8'hFE, 8'hFF: begin
                        ext_f <= 1'b0;
                        rel_f <= 1'b0;
                    end
                    default: begin
                        // 0xAA is a self-test response unless it follows F0
                        if (byte_q != 8'hAA || rel_f) begin
                            ps2_key <= {~ps2_key[10], ~rel_f, ext_f, byte_q};
                        end
                        ext_f <= 1'b0;
                        rel_f <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
